// File: rtl/anemo_log_pkg.sv
// rtl/anemo_log_pkg.sv - shared FSM encoding and record geometry for the MM logger
package anemo_log_pkg;
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_WR_TS   = 2'd1;
    localparam state_t ST_WR_DATA = 2'd2;

    // One record is a timestamp word followed by the sample word.
    localparam int REC_WORDS = 2;
endpackage

// File: rtl/anemo_ring_ptr.sv
// rtl/anemo_ring_ptr.sv - wrap-aware ring write pointer, saturating record count and wrap flag
module anemo_ring_ptr #(
    parameter int DEPTH_WORDS = 5000,
    parameter int ADDR_W      = 13
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clear_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] wr_ptr_o,
    output logic [15:0]       rec_count_o,
    output logic              wrapped_o
);
    import anemo_log_pkg::*;

    localparam logic [15:0] MAX_RECS = 16'(DEPTH_WORDS / REC_WORDS);

    logic [ADDR_W-1:0] ptr_q;
    logic [15:0]       count_q;
    logic              wrapped_q;
    logic [ADDR_W:0]   ptr_sum;
    logic              at_end;

    // One extra bit so a ring that fills the whole address space still compares correctly.
    assign ptr_sum = {1'b0, ptr_q} + (ADDR_W+1)'(REC_WORDS);
    assign at_end  = (ptr_sum == (ADDR_W+1)'(DEPTH_WORDS));

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            ptr_q     <= '0;
            count_q   <= '0;
            wrapped_q <= 1'b0;
        end else if (advance_i) begin
            ptr_q <= at_end ? '0 : ptr_sum[ADDR_W-1:0];
            if (at_end) begin
                wrapped_q <= 1'b1;
            end
            if (count_q != MAX_RECS) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign wr_ptr_o    = ptr_q;
    assign rec_count_o = count_q;
    assign wrapped_o   = wrapped_q;
endmodule

// File: rtl/anemo_mm_logger.sv
// rtl/anemo_mm_logger.sv - timestamped sample logger writing two-word records into an Avalon-MM ring
module anemo_mm_logger #(
    parameter int BASE_ADDR   = 0,
    parameter int DEPTH_WORDS = 5000,
    parameter int ADDR_W      = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [15:0]       rec_count,
    output logic              wrapped,
    output logic [15:0]       drop_count
);
    import anemo_log_pkg::*;

    state_t            state_q, state_d;
    logic [31:0]       ts_q;
    logic [31:0]       sample_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic              pend_q;
    logic [15:0]       drop_q;
    logic              idle, start, do_clear, ts_acc, rec_done;

    assign idle     = (state_q == ST_IDLE);
    // A pending clear behaves like a fresh clear: it wins over a coincident sample.
    assign do_clear = idle && (clear || pend_q);
    assign start    = idle && enable && in_valid && !clear && !pend_q;
    assign ts_acc   = (state_q == ST_WR_TS) && !avm_waitrequest;
    assign rec_done = (state_q == ST_WR_DATA) && !avm_waitrequest;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start)            state_d = ST_WR_TS;
            ST_WR_TS:   if (!avm_waitrequest) state_d = ST_WR_DATA;
            ST_WR_DATA: if (!avm_waitrequest) state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ts_q     <= '0;
            sample_q <= '0;
            wdata_q  <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            pend_q   <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_q + 32'd1;
            // Address/data registers only move on a new record or a timestamp handoff.
            if (start) begin
                write_q  <= 1'b1;
                addr_q   <= ADDR_W'(BASE_ADDR) + wr_ptr;
                wdata_q  <= ts_q;
                sample_q <= in_data;
            end else if (ts_acc) begin
                addr_q  <= addr_q + ADDR_W'(1);
                wdata_q <= sample_q;
            end else if (rec_done) begin
                write_q <= 1'b0;
            end
            if (do_clear) begin
                pend_q <= 1'b0;
            end else if (!idle && clear) begin
                pend_q <= 1'b1;
            end
            if (do_clear) begin
                drop_q <= '0;
            end else if (!idle && enable && in_valid && drop_q != 16'hFFFF) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    anemo_ring_ptr #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_ring_ptr (
        .clk_i       (clk),
        .reset_i     (reset),
        .clear_i     (do_clear),
        .advance_i   (rec_done),
        .wr_ptr_o    (wr_ptr),
        .rec_count_o (rec_count),
        .wrapped_o   (wrapped)
    );

    assign avm_address    = addr_q;
    assign avm_write      = write_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = 4'hF;
    assign busy           = !idle;
    assign drop_count     = drop_q;
endmodule

// File: tb/tb_anemo_mm_logger.sv
// tb/tb_anemo_mm_logger.sv - self-checking bench for anemo_mm_logger
module tb_anemo_mm_logger;
    localparam int BASE  = 0;
    localparam int DEPTH = 6;
    localparam int AW    = 13;

    logic          clk = 1'b0;
    logic          reset = 1'b1, enable = 1'b0, clear = 1'b0, in_valid = 1'b0, avm_waitrequest = 1'b0;
    logic [31:0]   in_data = '0;
    logic [AW-1:0] avm_address, wr_ptr;
    logic          avm_write, busy, wrapped;
    logic [31:0]   avm_writedata;
    logic [3:0]    avm_byteenable;
    logic [15:0]   rec_count, drop_count;

    always #5 clk = ~clk;

    anemo_mm_logger #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .in_valid(in_valid), .in_data(in_data),
        .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
        .busy(busy), .wr_ptr(wr_ptr), .rec_count(rec_count), .wrapped(wrapped),
        .drop_count(drop_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a record is two pending beats; beats are expected in queue order.
    typedef struct { int addr; logic [31:0] data; } beat_t;
    beat_t       exp_q[$];
    logic [31:0] m_ts;
    int          m_beats, m_ptr, m_cnt, m_drop;
    bit          m_wrap, m_pend, m_valid = 1'b0, hold_exp = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [31:0]   prev_wdata;

    typedef struct {
        bit e, c, v, w;
        logic [31:0] d;
        bit x_busy;
        int x_ptr, x_cnt, x_drop;
    } vec_t;
    vec_t tbl[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit c, input bit v,
                        input logic [31:0] d, input bit w);
        beat_t b;
        @(negedge clk);
        reset = r; enable = e; clear = c; in_valid = v; in_data = d; avm_waitrequest = w;
        if (m_valid) begin
            chk("busy", busy, m_beats != 0);
            chk("avm_write", avm_write, m_beats != 0);
            chk("wr_ptr", wr_ptr, m_ptr);
            chk("rec_count", rec_count, m_cnt);
            chk("wrapped", wrapped, m_wrap);
            chk("drop_count", drop_count, m_drop);
            chk("byteenable", avm_byteenable, 4'hF);
            if (hold_exp) begin
                chk("hold_addr", avm_address, prev_addr);
                chk("hold_data", avm_writedata, prev_wdata);
            end
            if (m_beats != 0 && !w) begin
                if (exp_q.size() == 0) begin
                    chk("beat_expected", 1, 0);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_addr", avm_address, b.addr);
                    chk("beat_data", avm_writedata, b.data);
                end
            end
        end
        prev_addr  = avm_address;
        prev_wdata = avm_writedata;
        if (r) begin
            m_ts = 0; m_beats = 0; m_ptr = 0; m_cnt = 0; m_drop = 0;
            m_wrap = 0; m_pend = 0; hold_exp = 0; m_valid = 1;
            exp_q.delete();
        end else begin
            hold_exp = 1;
            if (m_beats == 0) begin
                if (c || m_pend) begin
                    m_ptr = 0; m_cnt = 0; m_drop = 0; m_wrap = 0; m_pend = 0;
                end else if (e && v) begin
                    exp_q.push_back('{BASE + m_ptr, m_ts});
                    exp_q.push_back('{BASE + m_ptr + 1, d});
                    m_beats  = 2;
                    hold_exp = 0;
                end
            end else begin
                if (e && v && m_drop < 65535) m_drop++;
                if (c) m_pend = 1;
                if (!w) begin
                    if (m_beats == 2) hold_exp = 0;
                    m_beats--;
                    if (m_beats == 0) begin
                        m_ptr += 2;
                        if (m_ptr == DEPTH) begin
                            m_ptr  = 0;
                            m_wrap = 1;
                        end
                        if (m_cnt < DEPTH / 2) m_cnt++;
                    end
                end
            end
            m_ts = m_ts + 32'd1;
        end
    endtask

    task automatic idle_step();
        step(0, 1, 0, 0, 32'h0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 32'h0, 0);
        step(1, 0, 0, 0, 32'h0, 0);
    endtask

    initial begin
        logic [31:0] ts_exp;

        //             e  c  v  w  d             busy ptr cnt drop
        tbl[0]  = '{1, 0, 1, 0, 32'h0000ABCD, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 1, 0, 32'h0,        1, 0, 0, 0};
        tbl[2]  = '{1, 0, 1, 0, 32'h0,        1, 0, 0, 1};
        tbl[3]  = '{0, 0, 0, 0, 32'h0,        0, 2, 1, 2};
        tbl[4]  = '{0, 0, 1, 0, 32'h0,        0, 2, 1, 2};
        tbl[5]  = '{1, 1, 1, 0, 32'h0,        0, 2, 1, 2};
        tbl[6]  = '{1, 0, 0, 0, 32'h0,        0, 0, 0, 0};
        tbl[7]  = '{1, 0, 1, 1, 32'h5,        0, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 1, 32'h0,        1, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 32'h0,        1, 0, 0, 0};
        tbl[10] = '{0, 0, 1, 0, 32'h0,        1, 0, 0, 0};
        tbl[11] = '{1, 0, 1, 0, 32'h6,        0, 2, 1, 0};
        tbl[12] = '{1, 0, 0, 0, 32'h0,        1, 2, 1, 0};
        tbl[13] = '{1, 0, 0, 0, 32'h0,        1, 2, 1, 0};
        tbl[14] = '{1, 0, 0, 0, 32'h0,        0, 4, 2, 0};

        // Single sample: timestamp is 3 after three idle cycles following reset.
        do_reset();
        chk("reset_write", avm_write, 0);
        chk("reset_addr", avm_address, 0);
        chk("reset_data", avm_writedata, 0);
        chk("reset_be", avm_byteenable, 4'hF);
        idle_step(); idle_step(); idle_step();
        step(0, 1, 0, 1, 32'h0000ABCD, 0);
        idle_step();
        chk("single_ts_addr", avm_address, 0);
        chk("single_ts_data", avm_writedata, 32'd3);
        idle_step();
        chk("single_smp_addr", avm_address, 1);
        chk("single_smp_data", avm_writedata, 32'h0000ABCD);
        idle_step();
        chk("single_wr_ptr", wr_ptr, 2);
        chk("single_rec_count", rec_count, 1);
        chk("single_write_off", avm_write, 0);

        // Directed table: drops, enable gating, clear priority, early-disable, re-accept.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            step(0, tbl[i].e, tbl[i].c, tbl[i].v, tbl[i].d, tbl[i].w);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].x_busy);
            chk($sformatf("tbl%0d_ptr", i), wr_ptr, tbl[i].x_ptr);
            chk($sformatf("tbl%0d_cnt", i), rec_count, tbl[i].x_cnt);
            chk($sformatf("tbl%0d_drop", i), drop_count, tbl[i].x_drop);
        end

        // Stall in WR_TS for 4 cycles at ptr 4.
        step(0, 1, 0, 1, 32'h1234, 1);
        ts_exp = exp_q[0].data;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 0, 32'h0, 1);
            chk("stall_write", avm_write, 1);
            chk("stall_addr", avm_address, 4);
            chk("stall_data", avm_writedata, ts_exp);
        end
        step(0, 1, 0, 0, 32'h0, 0);
        idle_step();
        chk("stall_next_addr", avm_address, 5);
        chk("stall_next_data", avm_writedata, 32'h1234);
        idle_step();
        chk("stall_wrap_ptr", wr_ptr, 0);
        chk("stall_wrapped", wrapped, 1);

        // Pending clear raised during a stalled WR_DATA.
        step(0, 1, 0, 1, 32'h55, 0);
        step(0, 1, 0, 1, 32'h0, 0);
        step(0, 1, 1, 0, 32'h0, 1);
        step(0, 1, 0, 0, 32'h0, 1);
        step(0, 1, 0, 0, 32'h0, 0);
        step(0, 1, 0, 1, 32'h77, 0);
        chk("pend_busy", busy, 0);
        chk("pend_ptr_before", wr_ptr, 2);
        chk("pend_drop_before", drop_count, 1);
        idle_step();
        chk("pend_ptr", wr_ptr, 0);
        chk("pend_cnt", rec_count, 0);
        chk("pend_drop", drop_count, 0);
        chk("pend_wrapped", wrapped, 0);
        chk("pend_discard_busy", busy, 0);

        // Wrap: four records into a 6-word ring.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 1, 32'h100 + i, 0);
            idle_step();
            if (i == 3) chk("wrap_ts_addr", avm_address, 0);
            idle_step();
            if (i == 3) chk("wrap_smp_addr", avm_address, 1);
        end
        idle_step();
        chk("wrap_wrapped", wrapped, 1);
        chk("wrap_cnt", rec_count, 3);
        chk("wrap_ptr", wr_ptr, 2);

        // Reset while in WR_TS.
        step(0, 1, 0, 1, 32'h99, 1);
        step(1, 1, 0, 1, 32'h0, 0);
        chk("rst_mid_write_before", avm_write, 1);
        idle_step();
        chk("rst_mid_write", avm_write, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ptr", wr_ptr, 0);
        chk("rst_mid_cnt", rec_count, 0);
        chk("rst_mid_wrapped", wrapped, 0);
        chk("rst_mid_drop", drop_count, 0);
        idle_step();
        chk("rst_mid_no_beat", avm_write, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1,
                 $urandom, $urandom_range(0, 2) == 0);
        end
        for (int i = 0; i < 20; i++) idle_step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
